commit_store_buffer: RTL and testbench
======================================

# commit_store_buffer

Post-commit store buffer between the reorder buffer's memory-write port and the data memory. Committed stores are accepted in one cycle and the ROB keeps retiring without stalling on memory write latency. Entries drain to data memory in program order through a request/done handshake. Pending stores are exposed to the load unit so it can forward data or wait on an address conflict.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2
- ADDR_W, 32, byte-address width
- DATA_W, 32, store data width
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  ROB commits a store this cycle (ROB memory write enable)
- in_addr  in  ADDR_W  store byte address
- in_data  in  DATA_W  store data, right-aligned
- in_type  in  2  store width: 00 word, 01 half, 10 byte; 11 is illegal
- in_ready  out  1  buffer can accept (count < DEPTH)
- mem_req  out  1  write request to data memory
- mem_addr  out  ADDR_W  head entry address
- mem_data  out  DATA_W  head entry data
- mem_type  out  2  head entry width
- mem_done  in  1  data memory write-complete pulse
- ld_addr  in  ADDR_W  load unit address under lookup
- ld_hit  out  1  forwarding hit (STORE_FWD_EN only)
- ld_data  out  DATA_W  forwarded word
- ld_conflict  out  1  pending store overlaps ld_addr; the load must wait
- empty  out  1  no pending stores; used by the end-of-run check before memory dump
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Storage is a circular FIFO with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a separate count register.
- Push: when in_valid & in_ready, write {addr, data, type} at tail, advance tail, increment count.
- in_valid while !in_ready is a protocol error. The entry is dropped, and a simulation $display reports it.
- Drain FSM:
  - IDLE: if count != 0, go to REQ.
  - REQ: mem_req=1 and mem_* come from head. On mem_done, pop head, decrement count, go to IDLE.
  - mem_done in IDLE is ignored.
- Entries stay in REQ until written. The ROB's resetAll (misprediction flush) is NOT connected: committed stores are never flushed.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- in_ready is computed from the registered count only. A full buffer does not accept a push in the same cycle it pops.
- Lookup is combinational over valid entries and compares word addresses (ADDR_W-1:2).
  - Any match asserts ld_conflict, except when a forwarding hit occurs.
  - With forwarding: if the youngest matching entry is type word and ld_addr[1:0]==0, then ld_hit=1, ld_data=that entry's data, and ld_conflict=0.
- Arithmetic: count is computed without overflow since DEPTH entries fit. Data is not modified; width handling stays in data memory.

## Timing
- Reset values: in_ready=1, mem_req=0, mem_addr=0, mem_data=0, mem_type=0, ld_hit=0, ld_data=0, ld_conflict=0, empty=1, count=0, FSM=IDLE, head=tail=0.
- Push-to-request latency: entry pushed at edge N → FSM in REQ after edge N+1 → mem_req high during cycle N+1.
- mem_req is registered and stays high and stable until the edge at which mem_done is sampled high. It drops for at least one cycle (IDLE) between consecutive stores.
- Throughput: one store per 2 cycles plus the memory latency.
- Lookup reflects contents as of the last edge. A store pushed at edge N is visible to lookup from cycle N onward. The head entry remains visible until the pop edge.
- Reset asserted mid-REQ: mem_req drops asynchronously and all entries are lost.

## Configuration
- STORE_FWD_EN defined: word-aligned full-word hits forward as described above.
- STORE_FWD_EN undefined:
  - ld_hit is tied 0 and ld_data is tied 0.
  - Every address match asserts ld_conflict.
  - The forwarding mux is not built.

## Test plan
- Reset, then a single push (addr 12, data 5, type 00) → mem_req=1 one cycle later with mem_addr=12 and mem_data=5. mem_done after 3 cycles → empty=1, count=0.
- Push DEPTH=4 stores with mem_done held low → in_ready=0 at count=4. A fifth in_valid is dropped and flagged. A later mem_done → in_ready=1.
- Full buffer: pop and attempt a push in the same cycle → push rejected, count 4→3. In the steady state (count=2), push and pop together → count stays 2 and pointers wrap past index 3 correctly.
- STORE_FWD_EN, stores to addr 8 with data 3 then data 7, ld_addr=8 → ld_hit=1, ld_data=7. With ld_addr=9 → ld_hit=0, ld_conflict=1.
- STORE_FWD_EN off, same sequence → ld_hit=0, ld_conflict=1. ld_addr=16 → ld_conflict=0.
- Assert reset during REQ with 3 entries → mem_req=0 immediately, empty=1, and no mem write occurs after release.

Source files
------------

// File: rtl/commit_store_buffer.sv
// commit_store_buffer: post-commit store FIFO between the ROB write port and
// data memory. Stores drain in program order through a req/done handshake,
// and the load unit can look up pending stores for conflicts.
// Optional feature macro: STORE_FWD_EN enables word-aligned store-to-load
// forwarding. When it is undefined, ld_hit/ld_data are tied low and every
// address match reports a conflict.
module commit_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [1:0]               in_type,
  output logic                     in_ready,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data,
  output logic [1:0]               mem_type,
  input  logic                     mem_done,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hit,
  output logic [DATA_W-1:0]        ld_data,
  output logic                     ld_conflict,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              push;
  logic              pop;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [1:0]        type_mem [DEPTH];

  // Acceptance looks only at the registered count, so a full buffer refuses
  // a push even in the cycle it pops.
  assign in_ready = (count < CNT_W'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = (state == REQ) & mem_done;
  assign empty    = (count == '0);

  // Entry storage: written at the tail on an accepted push, never reset.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem[tail] <= in_addr;
      data_mem[tail] <= in_data;
      type_mem[tail] <= in_type;
    end
  end

  // Control state: pointers, occupancy and drain FSM register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= IDLE;
    end else begin
      state <= state_nxt;
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Drain FSM next state: request whenever something is pending, release on
  // done; the IDLE cycle between stores gives mem_req a guaranteed gap.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0) state_nxt = REQ;
      REQ:     if (mem_done)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory port: head entry presented only while requesting, zero otherwise.
  always_comb begin
    mem_req  = (state == REQ);
    mem_addr = '0;
    mem_data = '0;
    mem_type = '0;
    if (state == REQ) begin
      mem_addr = addr_mem[head];
      mem_data = data_mem[head];
      mem_type = type_mem[head];
    end
  end

  logic [PTR_W-1:0] idx;
  logic             match_any;

`ifdef STORE_FWD_EN
  logic              young_word;
  logic [DATA_W-1:0] young_data;

  // Load lookup with forwarding: scan oldest to youngest so the last match
  // wins; only an aligned full-word youngest match can forward.
  always_comb begin
    idx        = '0;
    match_any  = 1'b0;
    young_word = 1'b0;
    young_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) &&
          (addr_mem[idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
        match_any  = 1'b1;
        young_word = (type_mem[idx] == 2'b00);
        young_data = data_mem[idx];
      end
    end
    ld_hit      = match_any & young_word & (ld_addr[1:0] == 2'b00);
    ld_data     = ld_hit ? young_data : '0;
    ld_conflict = match_any & ~ld_hit;
  end
`else
  logic unused_ld_lsb;
  assign unused_ld_lsb = ^ld_addr[1:0];

  // Load lookup without forwarding: any word-address match makes the load wait.
  always_comb begin
    idx       = '0;
    match_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) &&
          (addr_mem[idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
        match_any = 1'b1;
      end
    end
    ld_hit      = 1'b0;
    ld_data     = '0;
    ld_conflict = match_any;
  end
`endif

`ifndef SYNTHESIS
  // Report committed stores lost because the ROB wrote into a full buffer.
  always @(posedge clock) begin
    if (!reset && in_valid && !in_ready)
      $display("commit_store_buffer: protocol error, store to %0h dropped (buffer full)", in_addr);
  end
`endif

endmodule

// File: tb/tb_commit_store_buffer.sv
// Self-checking bench for commit_store_buffer: directed scenarios plus
// randomized traffic, checked every cycle against a queue-based model.
module tb_commit_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_type;
  logic              in_ready;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [1:0]        mem_type;
  logic              mem_done;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;
  logic              ld_conflict;
  logic              empty;
  logic [$clog2(DEPTH):0] count;

  commit_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_type(in_type),
    .in_ready(in_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_type(mem_type),
    .mem_done(mem_done),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data), .ld_conflict(ld_conflict),
    .empty(empty), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [1:0]        typ;
  } st_t;

  // Reference model: pending stores in program order, plus whether the
  // oldest one is currently being requested from memory.
  st_t q[$];
  bit  m_req;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic [1:0]        et;
    bit                any;
    bit                yw;
    logic [DATA_W-1:0] yd;
    bit                ehit;
    bit                econf;
    logic [DATA_W-1:0] eld;
    ea = '0; ed = '0; et = '0;
    any = 1'b0; yw = 1'b0; yd = '0;
    if (m_req && q.size() != 0) begin
      ea = q[0].addr; ed = q[0].data; et = q[0].typ;
    end
    foreach (q[k]) begin
      if (q[k].addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]) begin
        any = 1'b1;
        yw  = (q[k].typ == 2'b00);
        yd  = q[k].data;
      end
    end
`ifdef STORE_FWD_EN
    ehit = any && yw && (ld_addr[1:0] == 2'b00);
    eld  = ehit ? yd : '0;
`else
    ehit = 1'b0;
    eld  = '0;
`endif
    econf = any && !ehit;
    chk({ph, ":in_ready"},    64'(in_ready),    64'(q.size() < DEPTH));
    chk({ph, ":count"},       64'(count),       64'(q.size()));
    chk({ph, ":empty"},       64'(empty),       64'(q.size() == 0));
    chk({ph, ":mem_req"},     64'(mem_req),     64'(m_req));
    chk({ph, ":mem_addr"},    64'(mem_addr),    64'(ea));
    chk({ph, ":mem_data"},    64'(mem_data),    64'(ed));
    chk({ph, ":mem_type"},    64'(mem_type),    64'(et));
    chk({ph, ":ld_hit"},      64'(ld_hit),      64'(ehit));
    chk({ph, ":ld_data"},     64'(ld_data),     64'(eld));
    chk({ph, ":ld_conflict"}, 64'(ld_conflict), 64'(econf));
  endtask

  // One clock: predict from current inputs and model state, then compare.
  task automatic cycle(input string ph);
    bit  pop;
    bit  push;
    bit  nreq;
    st_t e;
    pop    = m_req && mem_done;
    push   = in_valid && (q.size() < DEPTH);
    nreq   = m_req ? !mem_done : (q.size() != 0);
    e.addr = in_addr;
    e.data = in_data;
    e.typ  = in_type;
    @(posedge clock);
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(e);
    m_req = nreq;
    #1;
    check_all(ph);
  endtask

  task automatic push_one(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [1:0] t, input string ph);
    in_valid = 1'b1; in_addr = a; in_data = d; in_type = t;
    cycle(ph);
    in_valid = 1'b0;
  endtask

  // Asynchronous reset asserted mid-cycle, released on the falling edge.
  task automatic async_reset(input string ph);
    reset = 1'b1;
    #1;
    q.delete();
    m_req = 1'b0;
    check_all(ph);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic drain(input string ph);
    mem_done = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 4 * DEPTH + 4 && q.size() != 0; i++) cycle(ph);
    chk({ph, ":drained"}, 64'(q.size()), 64'(0));
    mem_done = 1'b0;
    cycle(ph);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; in_type = '0;
    mem_done = 1'b0; ld_addr = '0;
    q.delete(); m_req = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    @(negedge clock);
    reset = 1'b0;

    // Single store: request one cycle after the push, done three cycles later.
    push_one(32'd12, 32'd5, 2'b00, "t1_push");
    chk("t1_req_not_yet", 64'(mem_req), 64'(0));
    cycle("t1_wait");
    chk("t1_req",  64'(mem_req),  64'(1));
    chk("t1_addr", 64'(mem_addr), 64'(12));
    chk("t1_data", 64'(mem_data), 64'(5));
    cycle("t1_hold"); cycle("t1_hold");
    mem_done = 1'b1;
    cycle("t1_done");
    mem_done = 1'b0;
    chk("t1_empty", 64'(empty), 64'(1));
    chk("t1_count", 64'(count), 64'(0));

    // Fill to DEPTH with memory stalled, then overflow attempt.
    for (int k = 0; k < DEPTH; k++) push_one(32'h100 + 32'(4 * k), 32'hA0 + 32'(k), 2'b00, "t2_fill");
    chk("t2_full_ready", 64'(in_ready), 64'(0));
    chk("t2_full_count", 64'(count), 64'(4));
    push_one(32'h200, 32'hDEAD, 2'b00, "t2_overflow");
    chk("t2_dropped_count", 64'(count), 64'(4));
    chk("t2_head_kept", 64'(mem_addr), 64'(32'h100));

    // Pop and push in the same cycle while full: push refused.
    in_valid = 1'b1; in_addr = 32'h300; in_data = 32'h33; in_type = 2'b00;
    mem_done = 1'b1;
    cycle("t3_pop_push");
    in_valid = 1'b0; mem_done = 1'b0;
    chk("t3_count", 64'(count), 64'(3));
    chk("t3_ready", 64'(in_ready), 64'(1));

    // Bring occupancy to 2, then push exactly on each pop so count holds.
    mem_done = 1'b1;
    for (int i = 0; i < 8 && q.size() > 2; i++) cycle("t3_to2");
    for (int i = 0; i < 12; i++) begin
      in_valid = m_req;
      in_addr  = 32'h400 + 32'(4 * i);
      in_data  = 32'($urandom);
      in_type  = 2'($urandom_range(0, 2));
      cycle("t3_steady");
      chk("t3_steady_count", 64'(count), 64'(2));
    end
    in_valid = 1'b0;
    drain("t3_drain");

    // Two stores to the same word, younger one should forward.
    push_one(32'd8, 32'd3, 2'b00, "t4_push");
    push_one(32'd8, 32'd7, 2'b00, "t4_push");
    ld_addr = 32'd8;
    #1;
`ifdef STORE_FWD_EN
    chk("t4_hit8",  64'(ld_hit),      64'(1));
    chk("t4_data8", 64'(ld_data),     64'(7));
    chk("t4_conf8", 64'(ld_conflict), 64'(0));
`else
    chk("t4_hit8",  64'(ld_hit),      64'(0));
    chk("t4_data8", 64'(ld_data),     64'(0));
    chk("t4_conf8", 64'(ld_conflict), 64'(1));
`endif
    ld_addr = 32'd9;
    #1;
    chk("t4_hit9",  64'(ld_hit),      64'(0));
    chk("t4_conf9", 64'(ld_conflict), 64'(1));
    ld_addr = 32'd16;
    #1;
    chk("t4_hit16",  64'(ld_hit),      64'(0));
    chk("t4_conf16", 64'(ld_conflict), 64'(0));
    cycle("t4_check");
    drain("t4_drain");

    // Reset during a request with three entries pending.
    for (int k = 0; k < 3; k++) push_one(32'h500 + 32'(4 * k), 32'h50 + 32'(k), 2'b01, "t5_fill");
    chk("t5_req_before", 64'(mem_req), 64'(1));
    async_reset("t5_reset");
    chk("t5_req_drop", 64'(mem_req), 64'(0));
    chk("t5_empty",    64'(empty),   64'(1));
    mem_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle("t5_after");
      chk("t5_no_write", 64'(mem_req), 64'(0));
    end
    mem_done = 1'b0;

    // Randomized traffic over a small address pool to provoke lookups.
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_addr  = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      in_data  = 32'($urandom);
      in_type  = 2'($urandom_range(0, 2));
      mem_done = ($urandom_range(0, 3) == 0);
      ld_addr  = 32'($urandom_range(0, 9) * 4 + (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3)));
      if ($urandom_range(0, 299) == 0) async_reset("rnd_reset");
      else cycle("rnd");
    end
    in_valid = 1'b0;
    drain("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
